// File: rtl/dist_accel_csr_pkg.sv
// Shared definitions for the CSR-mapped distance accelerator.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dist_accel_pkg;

    // Byte offsets inside the 1 KiB CSR window
    localparam logic [9:0] OFF_CTRL     = 10'h000;
    localparam logic [9:0] OFF_STATUS   = 10'h004;
    localparam logic [9:0] OFF_COUNT    = 10'h008;
    localparam logic [9:0] OFF_REF      = 10'h00C;
    localparam logic [9:0] OFF_MIN_DIST = 10'h010;
    localparam logic [9:0] OFF_MIN_IDX  = 10'h014;
    localparam logic [9:0] OFF_POINT    = 10'h100;
    localparam logic [9:0] OFF_RES      = 10'h200;

    typedef enum logic {
        MODE_EUCLID2   = 1'b0,
        MODE_MANHATTAN = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_ABORT  = 3;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

endpackage

// File: rtl/dist_accel_csr_if.sv
// Split request/response CSR bus (xif) between a bus master and the accelerator.
// Latency: ack combinational, read response one cycle after acceptance.
// Backpressure: none; every request is accepted in the cycle it is presented.
// Signals: req_i/we_i/addr_bi/be_bi/wdata_bi (master->slave), ack_o/resp_o/rdata_bo (slave->master).
interface dist_accel_csr_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_bi;
    logic [3:0]  be_bi;
    logic [31:0] wdata_bi;
    logic        ack_o;
    logic        resp_o;
    logic [31:0] rdata_bo;

    modport slave (
        input  req_i, we_i, addr_bi, be_bi, wdata_bi,
        output ack_o, resp_o, rdata_bo
    );

    modport master (
        output req_i, we_i, addr_bi, be_bi, wdata_bi,
        input  ack_o, resp_o, rdata_bo
    );
endinterface

// File: rtl/dist_accel_csr_pipe.sv
// Two-stage distance datapath: |dx|,|dy| then squared-sum (saturating) or manhattan sum.
// Latency: 2 cycles from i_vld to o_vld; index travels alongside as sideband.
// Backpressure: none; i_flush drops everything in flight on the next edge.
// Ports: i_clk, i_arst_n, i_flush, i_vld/i_idx/i_pt, i_ref, i_mode -> o_vld/o_idx/o_res.
module dist_pipe
    import dist_accel_pkg::*;
#(
    parameter int CW    = 16,
    parameter int IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_flush,
    input  logic             i_vld,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [2*CW-1:0]  i_pt,
    input  logic [2*CW-1:0]  i_ref,
    input  mode_e            i_mode,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx,
    output logic [31:0]      o_res
);
    logic [CW-1:0]   w_x, w_y, w_rx, w_ry, w_dx, w_dy;
    logic            r_s1_vld, r_s2_vld;
    logic [IDX_W-1:0] r_s1_idx, r_s2_idx;
    logic [CW-1:0]   r_dx, r_dy;
    logic [31:0]     r_res;
    logic [2*CW-1:0] w_dx2, w_dy2;
    logic [2*CW:0]   w_sq_sum;
    logic [CW:0]     w_man;
    logic [31:0]     w_res;

    assign w_x  = i_pt[CW-1:0];
    assign w_y  = i_pt[2*CW-1:CW];
    assign w_rx = i_ref[CW-1:0];
    assign w_ry = i_ref[2*CW-1:CW];
    assign w_dx = (w_x >= w_rx) ? (w_x - w_rx) : (w_rx - w_x);
    assign w_dy = (w_y >= w_ry) ? (w_y - w_ry) : (w_ry - w_y);

    // Squares are formed at full width so the sum carry reaches bit 2*CW
    assign w_dx2    = {{CW{1'b0}}, r_dx} * {{CW{1'b0}}, r_dx};
    assign w_dy2    = {{CW{1'b0}}, r_dy} * {{CW{1'b0}}, r_dy};
    assign w_sq_sum = {1'b0, w_dx2} + {1'b0, w_dy2};
    assign w_man    = {1'b0, r_dx} + {1'b0, r_dy};
    assign w_res    = (i_mode == MODE_MANHATTAN) ? {{(31-CW){1'b0}}, w_man}
                    : (w_sq_sum[2*CW] ? 32'hFFFF_FFFF : w_sq_sum[2*CW-1:0]);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_idx <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_s2_vld <= 1'b0;
            r_s2_idx <= '0;
            r_res    <= '0;
        end else begin
            r_s1_vld <= i_vld & ~i_flush;
            r_s2_vld <= r_s1_vld & ~i_flush;
            if (i_vld) begin
                r_s1_idx <= i_idx;
                r_dx     <= w_dx;
                r_dy     <= w_dy;
            end
            if (r_s1_vld) begin
                r_s2_idx <= r_s1_idx;
                r_res    <= w_res;
            end
        end
    end

    assign o_vld = r_s2_vld;
    assign o_idx = r_s2_idx;
    assign o_res = r_res;
endmodule

// File: rtl/dist_accel_csr.sv
// CSR-mapped accelerator: distance of DEPTH points to REF, with min tracking and level irq.
// Latency: START in T -> BUSY at T+1, DONE at T+COUNT+3; bus reads respond at T+1.
// Backpressure: none; ack = req, conflicting writes while busy are dropped and flag ERR.
// Ports: clk_i, arst_n_i, bus (xif slave: req/we/addr/be/wdata -> ack/resp/rdata), irq_o.
module dist_accel_csr
    import dist_accel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0100,
    parameter int          DEPTH     = 16,
    parameter int          COORD_W   = 16
) (
    input  logic            clk_i,
    input  logic            arst_n_i,
    dist_accel_csr_if.slave bus,
    output logic            irq_o
);
    localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         NENT   = 1 << IDX_W;
    localparam logic [6:0] DEPTH7 = 7'(DEPTH);

    state_e           r_state, w_state_nxt;
    mode_e            r_mode;
    logic             r_irq_en, r_done, r_err, r_irq, r_drain, r_resp;
    logic [6:0]       r_count, r_k;
    logic [31:0]      r_ref, r_min_dist, r_rdata;
    logic [IDX_W-1:0] r_min_idx;
    logic [31:0]      r_pts [NENT];
    logic [31:0]      r_res [NENT];

    // Bus decode: the window is not 1 KiB aligned, so subtract the base
    logic [31:0]      w_off32, w_rd_dat;
    logic [9:0]       w_off;
    logic [5:0]       w_widx;
    logic [IDX_W-1:0] w_bidx;
    logic             w_in_win, w_idx_ok, w_is_pt, w_is_res, w_wr, w_rd, w_busy;
    logic             w_wr_ctrl, w_wr_stat, w_wr_cnt, w_wr_ref, w_wr_pt;
    logic             w_start, w_abort, w_issue, w_finish;
    logic             w_done_nxt, w_err_nxt, w_irq_en_nxt;
    logic             w_p_vld;
    logic [IDX_W-1:0] w_p_idx;
    logic [31:0]      w_p_res;
    logic             w_unused;

    assign w_off32   = bus.addr_bi - BASE_ADDR;
    assign w_in_win  = (w_off32[31:10] == '0);
    assign w_off     = w_off32[9:0];
    assign w_widx    = w_off[7:2];
    assign w_bidx    = w_widx[IDX_W-1:0];
    assign w_idx_ok  = ({1'b0, w_widx} < DEPTH7);
    assign w_is_pt   = (w_off[9:8] == OFF_POINT[9:8]) && w_idx_ok;
    assign w_is_res  = (w_off[9:8] == OFF_RES[9:8]) && w_idx_ok;
    assign w_wr      = bus.req_i & bus.we_i & w_in_win;
    assign w_rd      = bus.req_i & ~bus.we_i & w_in_win;
    assign w_wr_ctrl = w_wr && (w_off == OFF_CTRL);
    assign w_wr_stat = w_wr && (w_off == OFF_STATUS);
    assign w_wr_cnt  = w_wr && (w_off == OFF_COUNT);
    assign w_wr_ref  = w_wr && (w_off == OFF_REF);
    assign w_wr_pt   = w_wr && w_is_pt;
    assign w_abort   = w_wr_ctrl & bus.wdata_bi[CTRL_ABORT];
    assign w_start   = w_wr_ctrl & bus.wdata_bi[CTRL_START] & ~bus.wdata_bi[CTRL_ABORT];
    assign w_busy    = (r_state != ST_IDLE);
    assign w_unused  = ^bus.be_bi;

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_start && r_count != 7'd0) w_state_nxt = ST_RUN;
            ST_RUN: begin
                w_issue = 1'b1;
                if (r_k == r_count - 7'd1) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (r_drain) begin
                w_state_nxt = ST_IDLE;
                w_finish    = 1'b1;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_finish    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= (r_state == ST_RUN) ? r_k + 7'd1 : 7'd0;
            r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
        end
    end

    // Status next values; irq is registered from them so it tracks DONE without lag
    always_comb begin
        w_done_nxt   = r_done;
        w_err_nxt    = r_err;
        w_irq_en_nxt = r_irq_en;
        if (w_wr_stat && bus.wdata_bi[STAT_DONE]) w_done_nxt = 1'b0;
        if (w_wr_stat && bus.wdata_bi[STAT_ERR])  w_err_nxt  = 1'b0;
        if (w_wr_ctrl) w_irq_en_nxt = bus.wdata_bi[CTRL_IRQ_EN];
        if (w_busy && !w_abort && (w_wr_pt || w_wr_ref || w_wr_cnt || w_wr_ctrl)) w_err_nxt = 1'b1;
        if (!w_busy && w_start) begin
            w_done_nxt = (r_count == 7'd0);
            w_err_nxt  = 1'b0;
        end
        if (w_finish) w_done_nxt = 1'b1;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_mode   <= MODE_EUCLID2;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_irq    <= 1'b0;
            r_count  <= '0;
            r_ref    <= '0;
        end else begin
            r_irq_en <= w_irq_en_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_irq    <= w_done_nxt & w_irq_en_nxt;
            if (w_wr_ctrl && !w_busy) r_mode <= mode_e'(bus.wdata_bi[CTRL_MODE]);
            if (w_wr_cnt && !w_busy)
                r_count <= (bus.wdata_bi[6:0] > DEPTH7) ? DEPTH7 : bus.wdata_bi[6:0];
            if (w_wr_ref && !w_busy) r_ref <= bus.wdata_bi;
        end
    end

    dist_pipe #(.CW(COORD_W), .IDX_W(IDX_W)) u_pipe (
        .i_clk    (clk_i),
        .i_arst_n (arst_n_i),
        .i_flush  (w_abort),
        .i_vld    (w_issue),
        .i_idx    (r_k[IDX_W-1:0]),
        .i_pt     (r_pts[r_k[IDX_W-1:0]]),
        .i_ref    (r_ref),
        .i_mode   (r_mode),
        .o_vld    (w_p_vld),
        .o_idx    (w_p_idx),
        .o_res    (w_p_res)
    );

    // Point/result banks and strict-less-than minimum (lowest index wins ties)
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < NENT; i++) begin
                r_pts[i] <= '0;
                r_res[i] <= '0;
            end
            r_min_dist <= 32'hFFFF_FFFF;
            r_min_idx  <= '0;
        end else begin
            if (w_wr_pt && !w_busy) r_pts[w_bidx] <= bus.wdata_bi;
            if (w_start && !w_busy) begin
                r_min_dist <= 32'hFFFF_FFFF;
                r_min_idx  <= '0;
            end else if (w_p_vld) begin
                r_res[w_p_idx] <= w_p_res;
                if (w_p_res < r_min_dist) begin
                    r_min_dist <= w_p_res;
                    r_min_idx  <= w_p_idx;
                end
            end
        end
    end

    // Read mux
    always_comb begin
        w_rd_dat = '0;
        if (w_is_pt) begin
            w_rd_dat = r_pts[w_bidx];
        end else if (w_is_res) begin
            w_rd_dat = r_res[w_bidx];
        end else begin
            case (w_off)
                OFF_CTRL: begin
                    w_rd_dat[CTRL_MODE]   = r_mode;
                    w_rd_dat[CTRL_IRQ_EN] = r_irq_en;
                end
                OFF_STATUS: begin
                    w_rd_dat[STAT_BUSY] = w_busy;
                    w_rd_dat[STAT_DONE] = r_done;
                    w_rd_dat[STAT_ERR]  = r_err;
                end
                OFF_COUNT:    w_rd_dat[6:0]       = r_count;
                OFF_REF:      w_rd_dat            = r_ref;
                OFF_MIN_DIST: w_rd_dat            = r_min_dist;
                OFF_MIN_IDX:  w_rd_dat[IDX_W-1:0] = r_min_idx;
                default:      w_rd_dat            = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_resp  <= w_rd;
            r_rdata <= w_rd ? w_rd_dat : 32'd0;
        end
    end

    assign bus.ack_o    = bus.req_i;
    assign bus.resp_o   = r_resp;
    assign bus.rdata_bo = r_rdata;
    assign irq_o        = r_irq;
endmodule
